// File: rtl/and_or_xor_gates_pkg.sv
// Shared definitions for the and/or/xor gate block.
// Registered-result op encoding, counter width and a saturating increment.
package and_or_xor_gates_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_XNOR = 2'b11
  } op_e;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Operation counter sticks at all-ones rather than wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/and_or_xor_gates_gate_bitwise.sv
// Four bitwise functions of a and b, shared by the live outputs and the op mux.
// Latency: purely combinational. Backpressure: none.
module gate_bitwise #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y_and,
  output logic [WIDTH-1:0] y_or,
  output logic [WIDTH-1:0] y_xor,
  output logic [WIDTH-1:0] y_xnor
);

  assign y_and  = a & b;
  assign y_or   = a | b;
  assign y_xor  = a ^ b;
  assign y_xnor = ~(a ^ b);

endmodule

// File: rtl/and_or_xor_gates.sv
// Live AND/OR/XOR outputs plus an op-selected result registered on in_valid.
// Latency: 0 cycles combinational, 1 cycle registered. Backpressure: none, one op per cycle.
module and_or_xor_gates
  import and_or_xor_gates_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y_and,
  output logic [WIDTH-1:0] y_or,
  output logic [WIDTH-1:0] y_xor,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] cnt_q
);

  logic [WIDTH-1:0] xnor_w;
  logic [WIDTH-1:0] sel_dat;

  gate_bitwise #(
    .WIDTH (WIDTH)
  ) u_gate_bitwise (
    .a      (a),
    .b      (b),
    .y_and  (y_and),
    .y_or   (y_or),
    .y_xor  (y_xor),
    .y_xnor (xnor_w)
  );

  always_comb begin
    sel_dat = y_and;
    case (op_e'(op))
      OP_AND:  sel_dat = y_and;
      OP_OR:   sel_dat = y_or;
      OP_XOR:  sel_dat = y_xor;
      OP_XNOR: sel_dat = xnor_w;
      default: sel_dat = y_and;
    endcase
  end

  // op and operands only matter on an accepted cycle; otherwise the result holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      out_valid <= 1'b0;
      cnt_q     <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y_q   <= sel_dat;
        cnt_q <= sat_inc(cnt_q);
      end
    end
  end

endmodule

// File: tb/tb_and_or_xor_gates.sv
// Randomized bench for and_or_xor_gates against a truth-table reference model.
module tb_and_or_xor_gates;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_valid = 1'b0;
  logic [1:0]   op = '0;
  logic [W-1:0] y_and, y_or, y_xor, y_q;
  logic         out_valid;
  logic [15:0]  cnt_q;

  logic [0:0]   a1 = '0, b1 = '0;
  logic [0:0]   y_and1, y_or1, y_xor1, y_q1;
  logic         out_valid1;
  logic [15:0]  cnt_q1;
  logic         in_valid1 = 1'b0;
  logic [1:0]   op1 = '0;

  and_or_xor_gates #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .op(op),
    .y_and(y_and), .y_or(y_or), .y_xor(y_xor), .y_q(y_q),
    .out_valid(out_valid), .cnt_q(cnt_q)
  );

  and_or_xor_gates #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(in_valid1), .op(op1),
    .y_and(y_and1), .y_or(y_or1), .y_xor(y_xor1), .y_q(y_q1),
    .out_valid(out_valid1), .cnt_q(cnt_q1)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Truth tables indexed by {a_bit, b_bit}: AND, OR, XOR, XNOR.
  logic [3:0] op_tt [4] = '{4'b1000, 4'b1110, 4'b0110, 4'b1001};

  function automatic logic [W-1:0] gate_ref(input logic [3:0] tt, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) r[i] = tt[{x[i], y[i]}];
    return r;
  endfunction

  // Reference model: last accepted result, valid flag, saturating count.
  logic [W-1:0] m_yq  = '0;
  logic         m_ov  = 1'b0;
  int           m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_yq  <= '0;
      m_ov  <= 1'b0;
      m_cnt <= 0;
    end else begin
      m_ov <= in_valid;
      if (in_valid) begin
        m_yq  <= gate_ref(op_tt[op], a, b);
        m_cnt <= (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_y_and", 64'(y_and), 64'(gate_ref(op_tt[0], a, b)));
    chk("cmp_y_or", 64'(y_or), 64'(gate_ref(op_tt[1], a, b)));
    chk("cmp_y_xor", 64'(y_xor), 64'(gate_ref(op_tt[2], a, b)));
    chk("cmp_y_q", 64'(y_q), 64'(m_yq));
    chk("cmp_out_valid", 64'(out_valid), 64'(m_ov));
    chk("cmp_cnt_q", 64'(cnt_q), 64'(m_cnt));
    chk("cmp_w1_and", 64'(y_and1), 64'(a1 & b1));
    chk("cmp_w1_xor", 64'(y_xor1), 64'(a1 ^ b1));
  end

  logic [W-1:0] sel_exp [4] = '{8'h30, 8'hFC, 8'hCC, 8'h33};
  logic [2:0]   tt_exp  [4] = '{3'b000, 3'b011, 3'b011, 3'b110};

  initial begin
    logic [1:0] ab;

    // Reset state, with combinational outputs still live.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_y_q", 64'(y_q), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_cnt_q", 64'(cnt_q), 64'h0);
    a = 8'hA5; b = 8'h0F;
    #1;
    chk("rst_live_and", 64'(y_and), 64'h05);
    rst_n = 1'b1;

    // WIDTH=1 truth table sweep.
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      a1 = ab[1]; b1 = ab[0];
      #1;
      chk("tt_and_or_xor", 64'({y_and1, y_or1, y_xor1}), 64'(tt_exp[i]));
      #9;
    end

    // Registered select across all four ops, back to back.
    a = 8'hF0; b = 8'h3C; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op = 2'(i);
      @(posedge clk);
      #1;
      chk("sel_y_q", 64'(y_q), 64'(sel_exp[i]));
      chk("sel_out_valid", 64'(out_valid), 64'h1);
      chk("sel_cnt_q", 64'(cnt_q), 64'(i + 1));
    end
    in_valid = 1'b0;

    // Hold with op and operands wiggling while idle.
    for (int i = 0; i < 3; i++) begin
      op = 2'($urandom);
      a  = 8'($urandom);
      @(posedge clk);
      #1;
      chk("hold_y_q", 64'(y_q), 64'h33);
      chk("hold_out_valid", 64'(out_valid), 64'h0);
      chk("hold_cnt_q", 64'(cnt_q), 64'h4);
    end

    // Async reset in the middle of a stream.
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_y_q", 64'(y_q), 64'h0);
    chk("arst_out_valid", 64'(out_valid), 64'h0);
    chk("arst_cnt_q", 64'(cnt_q), 64'h0);
    chk("arst_live_and", 64'(y_and), 64'(a & b));
    @(posedge clk);
    #1;
    chk("arst_edge_cnt_q", 64'(cnt_q), 64'h0);
    chk("arst_edge_out_valid", 64'(out_valid), 64'h0);
    rst_n = 1'b1;
    a = 8'h5A; b = 8'hFF; op = 2'd3;
    @(posedge clk);
    #1;
    chk("post_rst_out_valid", 64'(out_valid), 64'h1);
    chk("post_rst_cnt_q", 64'(cnt_q), 64'h1);
    chk("post_rst_y_q", 64'(y_q), 64'h5A);

    // Random operands, ops and valid pattern.
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end

    // Counter saturation from a fresh reset.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
      @(posedge clk);
      #1;
      if (i == 65533) chk("sat_reach_cnt_q", 64'(cnt_q), 64'hFFFE);
    end
    chk("sat_cnt_q", 64'(cnt_q), 64'hFFFF);
    @(posedge clk);
    #1;
    chk("sat_hold_cnt_q", 64'(cnt_q), 64'hFFFF);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/and_or_xor_gates.md
AND_OR_XOR_GATES -- requirements
Module: and_or_xor_gates

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 1, operand bit width (legal range 1..64).
REQ-002 The block SHALL have one clock and an asynchronous active-low reset, with the ports below.
- clk  input  1  rising-edge clock, sole clock of the block.
- rst_n  input  1  asynchronous active-low reset.
REQ-003 The block SHALL have these data and control ports:
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  operands valid this cycle.
- op  input  2  registered-result select: 00 AND, 01 OR, 10 XOR, 11 XNOR.
- y_and  output  WIDTH  combinational a AND b.
- y_or  output  WIDTH  combinational a OR b.
- y_xor  output  WIDTH  combinational a XOR b.
- y_q  output  WIDTH  registered selected result.
- out_valid  output  1  y_q holds a new result this cycle.
- cnt_q  output  16  count of accepted operations.

Function
REQ-004 y_and, y_or and y_xor SHALL be purely combinational bitwise functions of a and b, independent of clk, rst_n and in_valid.
REQ-005 With WIDTH=1, the combinational outputs SHALL follow this truth table:
- 00 -> and 0, or 0, xor 0.
- 01 -> and 0, or 1, xor 1.
- 10 -> and 0, or 1, xor 1.
- 11 -> and 1, or 1, xor 0.
REQ-006 The combinational outputs SHALL settle within the same time step as an input change, with no clocked latency.
REQ-007 On a rising clk edge with in_valid=1, y_q SHALL load the op-selected function of the current a and b, where XNOR is ~(a^b).
REQ-008 Registered latency SHALL be exactly 1 cycle: out_valid SHALL be 1 in the cycle after an accepted in_valid, and 0 otherwise.
REQ-009 When in_valid=0, y_q SHALL hold its previous value and out_valid SHALL fall to 0.
REQ-010 op SHALL be sampled only with in_valid=1; op changes while in_valid=0 SHALL have no effect.
REQ-011 cnt_q SHALL increment by 1 on each accepted operation and SHALL saturate at 16'hFFFF without wrapping.
REQ-012 Back-to-back in_valid cycles SHALL each produce a result, with no bubbles and full throughput.
REQ-013 X or Z on a or b SHALL propagate per standard bitwise semantics; the block SHALL perform no masking.

Reset
REQ-014 While rst_n=0, y_q SHALL be 0, out_valid SHALL be 0 and cnt_q SHALL be 0, asserted asynchronously without waiting for clk.
REQ-015 Reset deassertion SHALL be synchronised externally; the first edge after release SHALL accept in_valid normally.
REQ-016 Reset asserted mid-operation SHALL discard any pending result, so out_valid=0 and no count is taken for that cycle.
REQ-017 The combinational outputs SHALL remain live during reset.

Structure
REQ-018 A shared package SHALL define:
- the op encoding enum with values OP_AND, OP_OR, OP_XOR, OP_XNOR;
- the counter width constant CNT_W=16.
REQ-019 One sub-module, gate_bitwise, SHALL compute the four WIDTH-bit bitwise results.
- It is instantiated once.
- It feeds both the combinational outputs and the op multiplexer.
REQ-020 All sequential logic SHALL reside in the top module in a single always block on clk/rst_n.

Verification
REQ-021 Truth-table sweep: WIDTH=1, apply ab=00,01,10,11 with 10 ns between each -> (and,or,xor) = (0,0,0), (0,1,1), (0,1,1), (1,1,0).
REQ-022 Registered select: WIDTH=8, a=8'hF0, b=8'h3C, in_valid=1 with op=0,1,2,3 on consecutive cycles -> y_q = 30, FC, CC, 33 (hex) one cycle later, out_valid=1 for 4 cycles.
REQ-023 Hold: in_valid=0 for 3 cycles after a result -> y_q unchanged, out_valid=0, cnt_q unchanged.
REQ-024 Async reset: assert rst_n=0 between clock edges during streaming -> y_q=0, out_valid=0, cnt_q=0 immediately; y_and still equals a&b.
REQ-025 Saturation: force 65,536 accepted operations -> cnt_q stays 16'hFFFF.
REQ-026 Random: 1,000 random a, b, op and in_valid values at WIDTH=8 -> every output matches a reference model each cycle.
